// File: rtl/ingress_arb_8x10.sv
// Dual 8-entry ingress FIFOs with a round-robin single-pop arbiter feeding the router's 2:1 mux.
// A head word may only pop when the destination selected by its class bit is not paused.
module ingress_arb_8x10 #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push0,
  input  logic                  push1,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic                  dest_pause0,
  input  logic                  dest_pause1,
  output logic [DATA_WIDTH-1:0] in0,
  output logic [DATA_WIDTH-1:0] in1,
  output logic                  emptyF0,
  output logic                  emptyF1,
  output logic                  full0,
  output logic                  full1,
  output logic                  almost_full0,
  output logic                  almost_full1,
  output logic                  almost_empty0,
  output logic                  almost_empty1,
  output logic                  error0,
  output logic                  error1
);

  localparam int CW        = ADDR_WIDTH + 1;
  localparam int CLASS_BIT = 8;

  localparam logic [CW-1:0]         CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0]         CNT_AE    = CW'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

  logic [DATA_WIDTH-1:0] mem_q    [2][DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q [2];
  logic [ADDR_WIDTH-1:0] wr_ptr_d [2];
  logic [ADDR_WIDTH-1:0] rd_ptr_q [2];
  logic [ADDR_WIDTH-1:0] rd_ptr_d [2];
  logic [CW-1:0]         count_q  [2];
  logic [CW-1:0]         count_d  [2];
  logic [DATA_WIDTH-1:0] in_q     [2];
  logic [DATA_WIDTH-1:0] head_s   [2];
  logic [DATA_WIDTH-1:0] wdata_s  [2];
  logic                  last_grant_q;
  logic                  last_grant_d;
  logic [1:0]            empty_f_q;
  logic [1:0]            full_q;
  logic [1:0]            af_q;
  logic [1:0]            ae_q;
  logic [1:0]            err_q;
  logic [1:0]            pause_s;
  logic [1:0]            push_s;
  logic [1:0]            elig_s;
  logic [1:0]            pop_s;
  logic [1:0]            push_acc_s;
  logic [1:0]            ovf_s;

  // Eligibility, round-robin grant, push acceptance and next pointer/count state.
  always_comb begin
    pause_s    = {dest_pause1, dest_pause0};
    push_s     = {push1, push0};
    wdata_s[0] = data_in0;
    wdata_s[1] = data_in1;
    elig_s     = 2'b00;
    push_acc_s = 2'b00;
    ovf_s      = 2'b00;
    for (int k = 0; k < 2; k++) begin
      head_s[k]    = mem_q[k][rd_ptr_q[k]];
      elig_s[k]    = (count_q[k] != CNT_ZERO) && !pause_s[head_s[k][CLASS_BIT]];
    end
    if (elig_s == 2'b11) begin
      pop_s = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      pop_s = elig_s;
    end
    if (pop_s[0]) begin
      last_grant_d = 1'b0;
    end else if (pop_s[1]) begin
      last_grant_d = 1'b1;
    end else begin
      last_grant_d = last_grant_q;
    end
    // A full FIFO still takes a push when its head leaves in the same cycle.
    for (int k = 0; k < 2; k++) begin
      push_acc_s[k] = push_s[k] && ((count_q[k] != CNT_FULL) || pop_s[k]);
      ovf_s[k]      = push_s[k] && (count_q[k] == CNT_FULL) && !pop_s[k];
      wr_ptr_d[k]   = push_acc_s[k] ? (wr_ptr_q[k] + PTR_ONE) : wr_ptr_q[k];
      rd_ptr_d[k]   = pop_s[k] ? (rd_ptr_q[k] + PTR_ONE) : rd_ptr_q[k];
      if (push_acc_s[k] && !pop_s[k]) begin
        count_d[k] = count_q[k] + CNT_ONE;
      end else if (pop_s[k] && !push_acc_s[k]) begin
        count_d[k] = count_q[k] - CNT_ONE;
      end else begin
        count_d[k] = count_q[k];
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset && push_acc_s[k]) begin
        mem_q[k][wr_ptr_q[k]] <= wdata_s[k];
      end
    end
  end

  // Pointers, counts, arbiter history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr_q[k] <= PTR_ZERO;
        rd_ptr_q[k] <= PTR_ZERO;
        count_q[k]  <= CNT_ZERO;
        in_q[k]     <= DATA_ZERO;
      end
      last_grant_q <= 1'b1;
      empty_f_q    <= 2'b11;
      full_q       <= 2'b00;
      af_q         <= 2'b00;
      ae_q         <= 2'b11;
      err_q        <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        count_q[k]  <= count_d[k];
        if (pop_s[k]) begin
          in_q[k] <= head_s[k];
        end
        full_q[k] <= (count_d[k] == CNT_FULL);
        af_q[k]   <= (count_d[k] >= CNT_AF);
        ae_q[k]   <= (count_d[k] <= CNT_AE);
        err_q[k]  <= err_q[k] | ovf_s[k];
      end
      last_grant_q <= last_grant_d;
      empty_f_q    <= ~pop_s;
    end
  end

  assign in0           = in_q[0];
  assign in1           = in_q[1];
  assign emptyF0       = empty_f_q[0];
  assign emptyF1       = empty_f_q[1];
  assign full0         = full_q[0];
  assign full1         = full_q[1];
  assign almost_full0  = af_q[0];
  assign almost_full1  = af_q[1];
  assign almost_empty0 = ae_q[0];
  assign almost_empty1 = ae_q[1];
  assign error0        = err_q[0];
  assign error1        = err_q[1];

endmodule
